codec_config_seq: RTL and testbench
===================================

Name: codec_config_seq

Overview:
Sequences the audio codec's power-up register configuration through the existing i2c_write engine, using that engine's write/done handshake.
After reset it walks a fixed 11-entry register table, then hands the I2C writer over to single host-requested register writes, such as live volume or path changes from switches.
It sits between the top level and one i2c_write instance, replacing ad-hoc per-register handshake logic.

Parameters:
DEV_ADDR, 8'h34, I2C device address byte presented on i2c_addr.
STARTUP_CYCLES, 50_000, sys_clk cycles to wait after reset release before the first write.
GAP_CYCLES, 500, idle cycles between consecutive writes; also inserted after entry 0 (codec reset).
TIMEOUT_CYCLES, 5_000_000, maximum cycles i2c_done may take to change level in either handshake phase.

Ports:
sys_clk  in  1  system clock, 50 MHz.
rst  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse: rerun the full table; honoured only in READY or ERROR.
i2c_addr  out  8  device address to i2c_write; constant DEV_ADDR.
i2c_reg  out  8  register byte = {reg[6:0], value[8]}.
i2c_data  out  8  data byte = value[7:0].
i2c_write  out  1  write request to i2c_write.
i2c_done  in  1  completion from i2c_write.
host_req  in  1  level request for one host write; sampled only in READY.
host_reg  in  7  codec register number for the host write.
host_val  in  9  9-bit value for the host write.
host_ack  out  1  one-cycle pulse when the host write completes.
busy  out  1  high in every state except READY and ERROR.
config_done  out  1  high once the table has finished without error; cleared by start.
error  out  1  sticky timeout flag; cleared by start or reset.
index  out  4  current table entry, 0..10.

Behaviour:
- Reset values: i2c_write=0, host_ack=0, config_done=0, error=0, index=0, i2c_reg=0, i2c_data=0. busy=1 because reset enters WAIT_START.
- i2c_addr always equals DEV_ADDR.
- Table (register:value in hex), entries 0..10:
  - 0: 0F:000
  - 1: 06:000
  - 2: 00:017
  - 3: 01:017
  - 4: 02:079
  - 5: 03:079
  - 6: 04:010
  - 7: 05:000
  - 8: 07:00A
  - 9: 08:000
  - 10: 09:001
- States:
  - WAIT_START: count STARTUP_CYCLES, then go to LOAD with index=0.
  - LOAD: register i2c_reg and i2c_data from table[index], then go to ISSUE.
  - ISSUE: i2c_write=1. Wait for i2c_done=1, then go to RELEASE.
  - RELEASE: i2c_write=0. Wait for i2c_done=0, then go to GAP.
  - GAP: count GAP_CYCLES. Then:
    - Table source, index<10: index+1, go to LOAD.
    - Table source, index=10: set config_done, go to READY.
    - Host source: pulse host_ack, go to READY.
  - READY: busy=0.
    - start has priority over host_req: clear config_done and error, index=0, go to WAIT_START.
    - Otherwise host_req=1: latch host_reg and host_val, derive i2c_reg/i2c_data the same way as table entries, set host source, go to ISSUE.
  - ERROR: i2c_write=0, error=1, busy=0. Only start or reset leaves ERROR.
- Handshake rules:
  - i2c_reg and i2c_data stay stable from LOAD (or READY latch) until RELEASE exits.
  - i2c_write never re-asserts while i2c_done=1.
- Timeout: one counter, cleared on entry to ISSUE and again on entry to RELEASE. When it reaches TIMEOUT_CYCLES, go to ERROR. index holds the failing entry.
- Boundary conditions:
  - host_req during busy is ignored; the host holds it until host_ack.
  - start during busy is ignored.
  - host_req and start in the same READY cycle: start wins, and host_req is re-evaluated at the next READY.
  - i2c_done already 1 on entering ISSUE (stale) is treated as completion.
- Reset mid-operation: asynchronous return to reset values. The sequence restarts from WAIT_START at entry 0, never resuming mid-table.
- Counters are sized for the largest parameter. A parameter value of 0 means zero wait cycles.

Test Plan:
- Release rst. i2c_done responder returns done 100 cycles after write and clears 1 cycle after write drops. Required: 11 writes in table order; the first presents i2c_reg=0x1E, i2c_data=0x00; the ninth (entry 8) presents 0x0E/0x0A; the last presents 0x12/0x01; then config_done=1, busy=0, index=10.
- Gap check: measure from i2c_done falling to the next i2c_write rising. Required: GAP_CYCLES+1 cycles (1 for LOAD), and no overlap of writes.
- In READY, host_req=1 with host_reg=0x02 and host_val=0x17F. Required: one write with i2c_reg=0x05, i2c_data=0x7F; host_ack pulses once; config_done stays 1.
- Responder never asserts done on entry 3, with TIMEOUT_CYCLES=1000 for this test. Required: error=1, index=3, i2c_write=0 after 1000 cycles. A start pulse then clears error and replays from entry 0.
- Assert rst during entry 5's ISSUE. Required: outputs go to reset values immediately; after release, the first write is again 0x1E/0x00.
- host_req held high during the initial sequence. Required: not serviced until after entry 10 completes. host_req and start asserted in the same READY cycle: the table reruns first.

Source files
------------

// File: rtl/codec_config_seq_if.sv
// codec_config_seq_if: write/done handshake between the config sequencer and the i2c_write engine.
interface codec_config_seq_if;
  logic [7:0] i2c_addr;
  logic [7:0] i2c_reg;
  logic [7:0] i2c_data;
  logic       i2c_write;
  logic       i2c_done;
  modport master (output i2c_addr, i2c_reg, i2c_data, i2c_write, input i2c_done);
  modport slave (input i2c_addr, i2c_reg, i2c_data, i2c_write, output i2c_done);
endinterface

// File: rtl/codec_config_seq.sv
// codec_config_seq: walks the codec power-up register table through i2c_write, then serves single host writes.
module codec_config_seq #(
  parameter logic [7:0]  DEV_ADDR       = 8'h34,
  parameter int unsigned STARTUP_CYCLES = 50_000,
  parameter int unsigned GAP_CYCLES     = 500,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               start_i,
  codec_config_seq_if.master i2c,
  input  logic               host_req_i,
  input  logic [6:0]         host_reg_i,
  input  logic [8:0]         host_val_i,
  output logic               host_ack_o,
  output logic               busy_o,
  output logic               config_done_o,
  output logic               error_o,
  output logic [3:0]         index_o
);
  localparam int unsigned M1   = STARTUP_CYCLES > GAP_CYCLES ? STARTUP_CYCLES : GAP_CYCLES;
  localparam int unsigned MAXC = M1 > TIMEOUT_CYCLES ? M1 : TIMEOUT_CYCLES;
  localparam int          W    = $clog2(MAXC + 3);
  localparam logic [W-1:0] STARTUP_W = W'(STARTUP_CYCLES);
  localparam logic [W-1:0] GAP_W     = W'(GAP_CYCLES);
  localparam logic [W-1:0] TIMEOUT_W = W'(TIMEOUT_CYCLES);
  // The RELEASE cycle that sees done low is already the first idle cycle of the gap.
  localparam bit SKIP_GAP = GAP_CYCLES < 2;

  typedef enum logic [2:0] {WAIT_START, LOAD, ISSUE, RELEASE, GAP, READY, ERROR} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q;
  logic [3:0]   index_q, index_d;
  logic [7:0]   reg_q, reg_d, data_q, data_d;
  logic         host_src_q, host_src_d;
  logic         config_done_q, config_done_d;
  logic         error_q, error_d;
  logic [15:0]  tbl;
  logic         timeout, gap_fire, last;
  state_t       post;

  always_comb
    case (index_q)
      4'd0:    tbl = {7'h0F, 9'h000};
      4'd1:    tbl = {7'h06, 9'h000};
      4'd2:    tbl = {7'h00, 9'h017};
      4'd3:    tbl = {7'h01, 9'h017};
      4'd4:    tbl = {7'h02, 9'h079};
      4'd5:    tbl = {7'h03, 9'h079};
      4'd6:    tbl = {7'h04, 9'h010};
      4'd7:    tbl = {7'h05, 9'h000};
      4'd8:    tbl = {7'h07, 9'h00A};
      4'd9:    tbl = {7'h08, 9'h000};
      default: tbl = {7'h09, 9'h001};
    endcase

  assign timeout  = cnt_q + W'(1) >= TIMEOUT_W;
  assign last     = index_q == 4'd10;
  assign post     = (host_src_q || last) ? READY : LOAD;
  assign gap_fire = (state_q == GAP && cnt_q + W'(2) >= GAP_W) ||
                    (state_q == RELEASE && !i2c.i2c_done && SKIP_GAP);

  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    reg_d         = reg_q;
    data_d        = data_q;
    host_src_d    = host_src_q;
    config_done_d = config_done_q;
    error_d       = error_q;
    case (state_q)
      WAIT_START: if (cnt_q + W'(1) >= STARTUP_W) begin
        state_d = LOAD;
        index_d = '0;
      end
      LOAD: begin
        reg_d      = tbl[15:8];
        data_d     = tbl[7:0];
        host_src_d = 1'b0;
        state_d    = ISSUE;
      end
      ISSUE:   state_d = i2c.i2c_done ? RELEASE : timeout ? ERROR : ISSUE;
      RELEASE: state_d = !i2c.i2c_done ? (SKIP_GAP ? post : GAP) : timeout ? ERROR : RELEASE;
      GAP:     state_d = gap_fire ? post : GAP;
      READY, ERROR: if (start_i) begin
        state_d       = WAIT_START;
        index_d       = '0;
        host_src_d    = 1'b0;
        config_done_d = 1'b0;
        error_d       = 1'b0;
      end else if (state_q == READY && host_req_i) begin
        {reg_d, data_d} = {host_reg_i, host_val_i};
        host_src_d      = 1'b1;
        state_d         = ISSUE;
      end
      default: state_d = WAIT_START;
    endcase
    if (gap_fire && !host_src_q) begin
      config_done_d = last ? 1'b1 : config_done_q;
      index_d       = last ? index_q : index_q + 4'd1;
    end
    if (state_d == ERROR) error_d = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge rst)
    if (!rst) begin
      state_q       <= WAIT_START;
      cnt_q         <= '0;
      index_q       <= '0;
      reg_q         <= '0;
      data_q        <= '0;
      host_src_q    <= 1'b0;
      config_done_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= state_d != state_q ? '0 : cnt_q + W'(1);
      index_q       <= index_d;
      reg_q         <= reg_d;
      data_q        <= data_d;
      host_src_q    <= host_src_d;
      config_done_q <= config_done_d;
      error_q       <= error_d;
    end

  assign i2c.i2c_addr  = DEV_ADDR;
  assign i2c.i2c_reg   = reg_q;
  assign i2c.i2c_data  = data_q;
  assign i2c.i2c_write = state_q == ISSUE;
  assign host_ack_o    = gap_fire && host_src_q;
  assign busy_o        = !(state_q == READY || state_q == ERROR);
  assign config_done_o = config_done_q;
  assign error_o       = error_q;
  assign index_o       = index_q;
endmodule

// File: tb/tb_codec_config_seq.sv
// tb_codec_config_seq: directed phases with randomized host writes and responder latency, checked against a table model.
module tb_codec_config_seq;
  localparam int GAP = 8;
  localparam int TMO = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       host_req = 1'b0;
  logic [6:0] host_reg = '0;
  logic [8:0] host_val = '0;
  logic       host_ack, busy, config_done, error;
  logic [3:0] index;
  logic       done_r = 1'b0;

  codec_config_seq_if i2c ();
  assign i2c.i2c_done = done_r;

  codec_config_seq #(.DEV_ADDR(8'h34), .STARTUP_CYCLES(20), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .sys_clk(clk), .rst(rst), .start_i(start), .i2c(i2c),
    .host_req_i(host_req), .host_reg_i(host_reg), .host_val_i(host_val),
    .host_ack_o(host_ack), .busy_o(busy), .config_done_o(config_done),
    .error_o(error), .index_o(index));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int TREG[11] = '{'h0F, 'h06, 'h00, 'h01, 'h02, 'h03, 'h04, 'h05, 'h07, 'h08, 'h09};
  int TVAL[11] = '{'h000, 'h000, 'h017, 'h017, 'h079, 'h079, 'h010, 'h000, 'h00A, 'h000, 'h001};

  function automatic logic [15:0] exp_pair(input int r, input int v);
    return 16'((r * 2 + v / 256) * 256 + v % 256);
  endfunction

  // Responder: done rises lat cycles after write, drops the cycle after write falls.
  int lat = 100, lat_cnt = 0, stall_at = -1;
  logic [15:0] wr_log[$];
  int gap_log[$];
  always @(posedge clk)
    if (!i2c.i2c_write) begin
      lat_cnt <= 0;
      done_r  <= 1'b0;
    end else if (!(stall_at >= 0 && wr_log.size() == stall_at + 1)) begin
      lat_cnt <= lat_cnt + 1;
      if (lat_cnt + 1 >= lat) done_r <= 1'b1;
    end

  int cyc = 0, fall_cyc = 0, rise_cyc = 0, hi_len = 0, ack_cnt = 0, overlap = 0;
  logic wr_prev = 1'b0, done_prev = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (i2c.i2c_write && !wr_prev) begin
      wr_log.push_back({i2c.i2c_reg, i2c.i2c_data});
      gap_log.push_back(cyc - fall_cyc);
      rise_cyc = cyc;
      if (i2c.i2c_done) overlap++;
    end
    if (!i2c.i2c_write && wr_prev) hi_len = cyc - rise_cyc;
    if (!i2c.i2c_done && done_prev) fall_cyc = cyc;
    if (host_ack) ack_cnt++;
    wr_prev   = i2c.i2c_write;
    done_prev = i2c.i2c_done;
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_write"}, i2c.i2c_write, 1'b0);
    chk({p, "_ack"}, host_ack, 1'b0);
    chk({p, "_cfg"}, config_done, 1'b0);
    chk({p, "_err"}, error, 1'b0);
    chk({p, "_idx"}, index, 4'd0);
    chk({p, "_reg"}, i2c.i2c_reg, 8'h00);
    chk({p, "_data"}, i2c.i2c_data, 8'h00);
    chk({p, "_busy"}, busy, 1'b1);
    chk({p, "_addr"}, i2c.i2c_addr, 8'h34);
  endtask

  task automatic chk_table(input string p, input int b);
    for (int j = 0; j < 11; j++)
      chk($sformatf("%s_w%0d", p, j), wr_log[b + j], exp_pair(TREG[j], TVAL[j]));
  endtask

  task automatic wait_cfg(input string p);
    for (int n = 0; n < 5000 && !config_done; n++) tick;
    chk({p, "_cfg"}, config_done, 1'b1);
  endtask

  task automatic wait_ack(input string p, input int a0);
    for (int n = 0; n < 8000 && ack_cnt == a0; n++) tick;
    chk({p, "_ack_seen"}, ack_cnt != a0, 1'b1);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  initial begin
    int b, a0;
    repeat (3) tick;
    chk_reset("rst0");
    rst = 1'b1;

    // Power-up sequence
    wait_cfg("boot");
    chk("boot_nwr", wr_log.size(), 11);
    chk_table("boot", 0);
    chk("boot_first", wr_log[0], 16'h1E00);
    chk("boot_e8", wr_log[8], 16'h0E0A);
    chk("boot_last", wr_log[10], 16'h1201);
    for (int j = 1; j < 11; j++) chk($sformatf("boot_gap%0d", j), gap_log[j], GAP + 1);
    chk("boot_busy", busy, 1'b0);
    chk("boot_idx", index, 4'd10);

    // Host writes; first one is the fixed case, the rest random
    for (int k = 0; k < 4; k++) begin
      host_reg = k == 0 ? 7'h02 : 7'($urandom_range(0, 127));
      host_val = k == 0 ? 9'h17F : 9'($urandom_range(0, 511));
      lat = $urandom_range(1, 60);
      b = wr_log.size();
      a0 = ack_cnt;
      host_req = 1'b1;
      wait_ack($sformatf("host%0d", k), a0);
      host_req = 1'b0;
      repeat (5) tick;
      chk($sformatf("host%0d_nwr", k), wr_log.size() - b, 1);
      chk($sformatf("host%0d_pair", k), wr_log[b], exp_pair(int'(host_reg), int'(host_val)));
      chk($sformatf("host%0d_nack", k), ack_cnt - a0, 1);
      chk($sformatf("host%0d_cfg", k), config_done, 1'b1);
      chk($sformatf("host%0d_busy", k), busy, 1'b0);
    end
    chk("host0_fixed", exp_pair('h02, 'h17F), 16'h057F);
    lat = 100;

    // Timeout on entry 3, then recovery via start
    b = wr_log.size();
    stall_at = b + 3;
    pulse_start;
    for (int n = 0; n < 5000 && !error; n++) tick;
    chk("tmo_err", error, 1'b1);
    chk("tmo_idx", index, 4'd3);
    chk("tmo_write", i2c.i2c_write, 1'b0);
    chk("tmo_busy", busy, 1'b0);
    chk("tmo_cfg", config_done, 1'b0);
    chk("tmo_len", hi_len, TMO);
    chk("tmo_nwr", wr_log.size() - b, 4);
    stall_at = -1;
    b = wr_log.size();
    pulse_start;
    chk("rec_err", error, 1'b0);
    chk("rec_busy", busy, 1'b1);
    wait_cfg("rec");
    chk_table("rec", b);

    // Asynchronous reset during entry 5, host_req held through the replay
    b = wr_log.size();
    pulse_start;
    for (int n = 0; n < 5000 && wr_log.size() < b + 6; n++) tick;
    repeat (10) tick;
    chk("mid_in_issue", i2c.i2c_write, 1'b1);
    rst = 1'b0;
    #1;
    chk_reset("mid");
    repeat (3) tick;
    host_reg = 7'($urandom_range(0, 127));
    host_val = 9'($urandom_range(0, 511));
    host_req = 1'b1;
    b = wr_log.size();
    a0 = ack_cnt;
    rst = 1'b1;
    wait_ack("hold", a0);
    host_req = 1'b0;
    chk("hold_cfg", config_done, 1'b1);
    chk("hold_nwr", wr_log.size() - b, 12);
    chk_table("hold", b);
    chk("hold_host", wr_log[b + 11], exp_pair(int'(host_reg), int'(host_val)));

    // start and host_req in the same READY cycle: table reruns first
    repeat (3) tick;
    host_reg = 7'($urandom_range(0, 127));
    host_val = 9'($urandom_range(0, 511));
    b = wr_log.size();
    a0 = ack_cnt;
    host_req = 1'b1;
    pulse_start;
    chk("both_busy", busy, 1'b1);
    chk("both_cfg", config_done, 1'b0);
    wait_ack("both", a0);
    host_req = 1'b0;
    chk("both_nwr", wr_log.size() - b, 12);
    chk_table("both", b);
    chk("both_host", wr_log[b + 11], exp_pair(int'(host_reg), int'(host_val)));
    chk("overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
